wb_j1_arbiter: RTL and testbench

- Shares one Wishbone classic master port between the J1 instruction-fetch bus (ibus) and data bus (dbus).
- Supports slaves with wait states and error termination.
- Sits between the J1 core and the Wishbone interconnect. Unlike a zero-wait pass-through, it sequences each access as a registered cycle, returns data with an explicit ack, and aborts hung cycles with a timeout.

---
 rtl/wb_j1_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_j1_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_j1_arbiter.sv
// wb_j1_arbiter: shares one Wishbone classic master port between the J1
// instruction-fetch bus (ibus) and data bus (dbus). Each access is a
// registered Wishbone cycle. The served requester gets a one-cycle ack or
// err pulse. A cycle that hangs longer than TIMEOUT cycles is aborted with
// an error.
module wb_j1_arbiter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    // instruction fetch bus
    input  logic          ibus_re,
    input  logic [AW-1:0] ibus_adr,
    output logic [DW-1:0] ibus_dat,
    output logic          ibus_ack,
    output logic          ibus_err,
    // data bus
    input  logic          dbus_re,
    input  logic          dbus_we,
    input  logic [AW-1:0] dbus_adr,
    input  logic [DW-1:0] dbus_dat_m,
    output logic [DW-1:0] dbus_dat_s,
    output logic          dbus_ack,
    output logic          dbus_err,
    // Wishbone master port
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [AW-1:0] wb_adr,
    output logic [DW-1:0] wb_dat_m,
    input  logic [DW-1:0] wb_dat_s,
    input  logic          wb_ack,
    input  logic          wb_err,
    // status
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ICYC,
        DCYC
    } state_t;

    typedef enum logic {
        IBUS,
        DBUS
    } grant_t;

    // Counter only has to reach TIMEOUT-1; it saturates when TIMEOUT is 0.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_t        state;
    grant_t        last_grant;
    logic [CW-1:0] cnt;

    logic elig_i;
    logic elig_d;
    logic grant_i;
    logic grant_d;
    logic timed_out;
    logic term_ok;
    logic term_err;

    // Arbitration and termination decode.
    // A requester whose completion pulse is high this cycle is masked so
    // that its still-asserted stale request is not granted again.
    always_comb begin
        elig_i    = ibus_re & ~(ibus_ack | ibus_err);
        elig_d    = (dbus_re | dbus_we) & ~(dbus_ack | dbus_err);
        grant_d   = elig_d & (~elig_i | (last_grant == IBUS));
        grant_i   = elig_i & ~grant_d;
        timed_out = (TIMEOUT != 0) && (cnt == TO_LAST);
        term_ok   = wb_ack & ~wb_err;
        term_err  = wb_err | (~wb_ack & timed_out);
    end

    // Arbiter FSM with all bus and completion outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= IBUS;
            cnt        <= '0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_adr     <= '0;
            wb_dat_m   <= '0;
            ibus_dat   <= '0;
            ibus_ack   <= 1'b0;
            ibus_err   <= 1'b0;
            dbus_dat_s <= '0;
            dbus_ack   <= 1'b0;
            dbus_err   <= 1'b0;
        end else begin
            ibus_ack <= 1'b0;
            ibus_err <= 1'b0;
            dbus_ack <= 1'b0;
            dbus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state      <= DCYC;
                        last_grant <= DBUS;
                        cnt        <= '0;
                        wb_cyc     <= 1'b1;
                        wb_stb     <= 1'b1;
                        wb_we      <= dbus_we;
                        wb_adr     <= dbus_adr;
                        wb_dat_m   <= dbus_dat_m;
                    end else if (grant_i) begin
                        state      <= ICYC;
                        last_grant <= IBUS;
                        cnt        <= '0;
                        wb_cyc     <= 1'b1;
                        wb_stb     <= 1'b1;
                        wb_we      <= 1'b0;
                        wb_adr     <= ibus_adr;
                        wb_dat_m   <= '0;
                    end
                end
                ICYC, DCYC: begin
                    if (term_ok | term_err) begin
                        state  <= IDLE;
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        wb_we  <= 1'b0;
                        if (state == DCYC) begin
                            dbus_ack   <= term_ok;
                            dbus_err   <= term_err;
                            dbus_dat_s <= term_ok ? wb_dat_s : '0;
                        end else begin
                            ibus_ack   <= term_ok;
                            ibus_err   <= term_err;
                            ibus_dat   <= term_ok ? wb_dat_s : '0;
                        end
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy while a cycle is open or a completion pulse is still visible.
    always_comb begin
        busy = wb_cyc | ibus_ack | ibus_err | dbus_ack | dbus_err;
    end

endmodule

// File: tb/tb_wb_j1_arbiter.sv
// Directed testbench for wb_j1_arbiter (TIMEOUT=8): fetch, write with wait
// states, read ok/error, timeout, mid-cycle reset and round-robin contention.
module tb_wb_j1_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ibus_re;
    logic [AW-1:0] ibus_adr;
    logic [DW-1:0] ibus_dat;
    logic          ibus_ack;
    logic          ibus_err;
    logic          dbus_re;
    logic          dbus_we;
    logic [AW-1:0] dbus_adr;
    logic [DW-1:0] dbus_dat_m;
    logic [DW-1:0] dbus_dat_s;
    logic          dbus_ack;
    logic          dbus_err;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_m;
    logic [DW-1:0] wb_dat_s;
    logic          wb_ack;
    logic          wb_err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] e_cyc  = 8'b0101_0101;
    logic [7:0] e_dack = 8'b0010_0010;
    logic [7:0] e_iack = 8'b1000_1000;

    always #5 clk = ~clk;

    wb_j1_arbiter #(
        .AW     (AW),
        .DW     (DW),
        .TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ibus_re   (ibus_re),
        .ibus_adr  (ibus_adr),
        .ibus_dat  (ibus_dat),
        .ibus_ack  (ibus_ack),
        .ibus_err  (ibus_err),
        .dbus_re   (dbus_re),
        .dbus_we   (dbus_we),
        .dbus_adr  (dbus_adr),
        .dbus_dat_m(dbus_dat_m),
        .dbus_dat_s(dbus_dat_s),
        .dbus_ack  (dbus_ack),
        .dbus_err  (dbus_err),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_dat_m  (wb_dat_m),
        .wb_dat_s  (wb_dat_s),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ibus_re    = 1'b0;
        ibus_adr   = '0;
        dbus_re    = 1'b0;
        dbus_we    = 1'b0;
        dbus_adr   = '0;
        dbus_dat_m = '0;
        wb_dat_s   = '0;
        wb_ack     = 1'b0;
        wb_err     = 1'b0;
        tick();
        tick();

        // reset values
        chk1("rst_cyc", wb_cyc, 1'b0);
        chk1("rst_stb", wb_stb, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_iack", ibus_ack, 1'b0);
        chkw("rst_idat", ibus_dat, 16'h0000);
        chkw("rst_adr", wb_adr, 16'h0000);

        rst_n = 1'b1;
        tick();

        // slave ack/err while no cycle is open is ignored
        wb_ack = 1'b1;
        wb_err = 1'b1;
        tick();
        chk1("stray_dack", dbus_ack, 1'b0);
        chk1("stray_ierr", ibus_err, 1'b0);
        chk1("stray_busy", busy, 1'b0);
        wb_ack = 1'b0;
        wb_err = 1'b0;

        // single zero-wait fetch
        ibus_re  = 1'b1;
        ibus_adr = 16'h0010;
        tick();
        chk1("fetch_cyc", wb_cyc, 1'b1);
        chk1("fetch_stb", wb_stb, 1'b1);
        chk1("fetch_we", wb_we, 1'b0);
        chkw("fetch_adr", wb_adr, 16'h0010);
        chk1("fetch_early_ack", ibus_ack, 1'b0);
        wb_ack   = 1'b1;
        wb_dat_s = 16'h1234;
        tick();
        chk1("fetch_ack", ibus_ack, 1'b1);
        chkw("fetch_dat", ibus_dat, 16'h1234);
        chk1("fetch_cyc_off", wb_cyc, 1'b0);
        chk1("fetch_busy", busy, 1'b1);
        ibus_re = 1'b0;
        wb_ack  = 1'b0;
        tick();
        chk1("fetch_ack_pulse", ibus_ack, 1'b0);
        chkw("fetch_dat_hold", ibus_dat, 16'h1234);
        chk1("fetch_idle_busy", busy, 1'b0);

        // write with 3 wait states; dat_m is latched at grant
        dbus_we    = 1'b1;
        dbus_adr   = 16'h4000;
        dbus_dat_m = 16'hBEEF;
        tick();
        chk1("wr_cyc1", wb_cyc, 1'b1);
        chk1("wr_we1", wb_we, 1'b1);
        chkw("wr_adr", wb_adr, 16'h4000);
        chkw("wr_datm1", wb_dat_m, 16'hBEEF);
        dbus_dat_m = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("wr_cyc_w%0d", i), wb_cyc, 1'b1);
            chk1($sformatf("wr_we_w%0d", i), wb_we, 1'b1);
            chkw($sformatf("wr_datm_w%0d", i), wb_dat_m, 16'hBEEF);
            chk1($sformatf("wr_dack_w%0d", i), dbus_ack, 1'b0);
        end
        wb_ack   = 1'b1;
        wb_dat_s = 16'h5A5A;
        tick();
        chk1("wr_dack", dbus_ack, 1'b1);
        chk1("wr_derr", dbus_err, 1'b0);
        chk1("wr_cyc_off", wb_cyc, 1'b0);
        chk1("wr_we_off", wb_we, 1'b0);
        chkw("wr_dats", dbus_dat_s, 16'h5A5A);
        chkw("wr_idat_hold", ibus_dat, 16'h1234);
        dbus_we = 1'b0;
        wb_ack  = 1'b0;
        tick();
        chk1("wr_dack_pulse", dbus_ack, 1'b0);

        // zero-wait data read
        dbus_re  = 1'b1;
        dbus_adr = 16'h2000;
        tick();
        chk1("rd_cyc", wb_cyc, 1'b1);
        chk1("rd_we", wb_we, 1'b0);
        chkw("rd_adr", wb_adr, 16'h2000);
        wb_ack   = 1'b1;
        wb_dat_s = 16'hA5A5;
        tick();
        chk1("rd_dack", dbus_ack, 1'b1);
        chkw("rd_dats", dbus_dat_s, 16'hA5A5);
        dbus_re = 1'b0;
        wb_ack  = 1'b0;
        tick();

        // ack and err together: error wins, data cleared
        dbus_re  = 1'b1;
        dbus_adr = 16'h2002;
        tick();
        chk1("err_cyc", wb_cyc, 1'b1);
        wb_ack   = 1'b1;
        wb_err   = 1'b1;
        wb_dat_s = 16'hFFFF;
        tick();
        chk1("err_derr", dbus_err, 1'b1);
        chk1("err_dack", dbus_ack, 1'b0);
        chkw("err_dats", dbus_dat_s, 16'h0000);
        chkw("err_idat_hold", ibus_dat, 16'h1234);
        chk1("err_cyc_off", wb_cyc, 1'b0);
        dbus_re = 1'b0;
        wb_ack  = 1'b0;
        wb_err  = 1'b0;
        tick();
        chk1("err_derr_pulse", dbus_err, 1'b0);

        // timeout on an unanswered fetch
        ibus_re  = 1'b1;
        ibus_adr = 16'h0ABC;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk1($sformatf("to_cyc%0d", i), wb_cyc, 1'b1);
            chk1($sformatf("to_ierr%0d", i), ibus_err, 1'b0);
            tick();
        end
        chk1("to_cyc_off", wb_cyc, 1'b0);
        chk1("to_ierr", ibus_err, 1'b1);
        chk1("to_iack", ibus_ack, 1'b0);
        chkw("to_idat", ibus_dat, 16'h0000);
        ibus_re  = 1'b0;
        dbus_re  = 1'b1;
        dbus_adr = 16'h0DEF;
        tick();
        chk1("to_next_cyc", wb_cyc, 1'b1);
        chkw("to_next_adr", wb_adr, 16'h0DEF);
        wb_ack   = 1'b1;
        wb_dat_s = 16'h4242;
        tick();
        chk1("to_next_dack", dbus_ack, 1'b1);
        chkw("to_next_dats", dbus_dat_s, 16'h4242);
        dbus_re = 1'b0;
        wb_ack  = 1'b0;
        tick();
        chk1("to_next_busy", busy, 1'b0);

        // reset during an open dbus cycle with wait states
        dbus_re  = 1'b1;
        dbus_adr = 16'h3000;
        tick();
        chk1("mr_cyc1", wb_cyc, 1'b1);
        tick();
        chk1("mr_cyc2", wb_cyc, 1'b1);
        rst_n  = 1'b0;
        wb_ack = 1'b1;
        tick();
        chk1("mr_cyc", wb_cyc, 1'b0);
        chk1("mr_stb", wb_stb, 1'b0);
        chk1("mr_dack", dbus_ack, 1'b0);
        chk1("mr_derr", dbus_err, 1'b0);
        chk1("mr_busy", busy, 1'b0);
        chkw("mr_dats", dbus_dat_s, 16'h0000);
        chkw("mr_adr", wb_adr, 16'h0000);
        wb_ack   = 1'b0;
        ibus_re  = 1'b1;
        ibus_adr = 16'h0100;
        dbus_re  = 1'b1;
        dbus_adr = 16'h0200;
        tick();
        chk1("mr_hold_cyc", wb_cyc, 1'b0);

        // contention from reset: dbus, ibus, dbus, ibus
        rst_n    = 1'b1;
        wb_ack   = 1'b1;
        wb_dat_s = 16'h7777;
        tick();
        for (int k = 0; k < 8; k++) begin
            chk1($sformatf("ct_cyc%0d", k), wb_cyc, e_cyc[k]);
            chk1($sformatf("ct_dack%0d", k), dbus_ack, e_dack[k]);
            chk1($sformatf("ct_iack%0d", k), ibus_ack, e_iack[k]);
            if (k % 4 == 0) chkw($sformatf("ct_adr%0d", k), wb_adr, 16'h0200);
            if (k % 4 == 2) chkw($sformatf("ct_adr%0d", k), wb_adr, 16'h0100);
            if (k == 1) chkw("ct_dats", dbus_dat_s, 16'h7777);
            if (k == 3) chkw("ct_idat", ibus_dat, 16'h7777);
            if (k < 7) tick();
        end
        ibus_re = 1'b0;
        dbus_re = 1'b0;
        wb_ack  = 1'b0;
        tick();
        chk1("ct_end_cyc", wb_cyc, 1'b0);
        chk1("ct_end_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
